multicycle_ctrl: RTL

MULTICYCLE_CTRL -- requirements
Module: multicycle_ctrl

---
 rtl/multicycle_ctrl.sv | 178 +++++++++++++++++
 1 files changed

// File: rtl/multicycle_ctrl.sv
// Multicycle control FSM (FETCH/DECODE/EXEC/MEM/WB) with retired-instruction counter.
// Optional macro MULTICYCLE_CTRL_TRAP_EN: illegal opcodes enter a sticky TRAP state instead of retiring as NOPs.
module multicycle_ctrl #(
    parameter int CNT_W = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [31:0]      inst_code,
    input  logic             mem_ready,
    input  logic             branch_taken,
    output logic             mem_req,
    output logic             mem_we,
    output logic             mem_sel_data,
    output logic             ir_we,
    output logic             pc_we,
    output logic             alu_src_imm,
    output logic             reg_we,
    output logic [1:0]       pc_src,
    output logic [1:0]       wb_sel,
    output logic [2:0]       state,
    output logic             instr_done,
    output logic [CNT_W-1:0] instret,
    output logic             trap
);

    typedef enum logic [2:0] {
        S_FETCH  = 3'd0,
        S_DECODE = 3'd1,
        S_EXEC   = 3'd2,
        S_MEM    = 3'd3,
        S_WB     = 3'd4,
        S_TRAP   = 3'd5
    } state_t;

    localparam logic [6:0] OP_R     = 7'b0110011;
    localparam logic [6:0] OP_I     = 7'b0010011;
    localparam logic [6:0] OP_LOAD  = 7'b0000011;
    localparam logic [6:0] OP_STORE = 7'b0100011;
    localparam logic [6:0] OP_BR    = 7'b1100011;
    localparam logic [6:0] OP_JAL   = 7'b1101111;
    localparam logic [6:0] OP_JALR  = 7'b1100111;

    state_t           r_state;
    state_t           w_state_next;
    logic [CNT_W-1:0] r_instret;

    logic [6:0] w_opcode;
    logic       w_is_r, w_is_i, w_is_load, w_is_store, w_is_br, w_is_jal, w_is_jalr, w_legal;
    logic       w_unused_inst;

    assign w_opcode      = inst_code[6:0];
    assign w_unused_inst = &{1'b0, inst_code[31:7]};

    assign w_is_r     = (w_opcode == OP_R);
    assign w_is_i     = (w_opcode == OP_I);
    assign w_is_load  = (w_opcode == OP_LOAD);
    assign w_is_store = (w_opcode == OP_STORE);
    assign w_is_br    = (w_opcode == OP_BR);
    assign w_is_jal   = (w_opcode == OP_JAL);
    assign w_is_jalr  = (w_opcode == OP_JALR);
    assign w_legal    = w_is_r | w_is_i | w_is_load | w_is_store | w_is_br | w_is_jal | w_is_jalr;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state   <= S_FETCH;
            r_instret <= '0;
        end else begin
            r_state <= w_state_next;
            if (instr_done) begin
                r_instret <= r_instret + CNT_W'(1);
            end
        end
    end

    always_comb begin
        w_state_next = r_state;
        mem_req      = 1'b0;
        mem_we       = 1'b0;
        mem_sel_data = 1'b0;
        ir_we        = 1'b0;
        pc_we        = 1'b0;
        alu_src_imm  = 1'b0;
        reg_we       = 1'b0;
        pc_src       = 2'b00;
        wb_sel       = 2'b00;
        instr_done   = 1'b0;

        case (r_state)
            S_FETCH: begin
                mem_req = 1'b1;
                if (mem_ready) begin
                    ir_we        = 1'b1;
                    w_state_next = S_DECODE;
                end
            end
            S_DECODE: begin
                if (w_legal) begin
                    w_state_next = S_EXEC;
                end else begin
`ifdef MULTICYCLE_CTRL_TRAP_EN
                    w_state_next = S_TRAP;
`else
                    pc_we        = 1'b1;
                    instr_done   = 1'b1;
                    w_state_next = S_FETCH;
`endif
                end
            end
            S_EXEC: begin
                alu_src_imm = w_is_i | w_is_load | w_is_store | w_is_jalr;
                if (w_is_br) begin
                    pc_we        = 1'b1;
                    pc_src       = branch_taken ? 2'b01 : 2'b00;
                    instr_done   = 1'b1;
                    w_state_next = S_FETCH;
                end else if (w_is_load || w_is_store) begin
                    w_state_next = S_MEM;
                end else begin
                    w_state_next = S_WB;
                end
            end
            S_MEM: begin
                mem_req      = 1'b1;
                mem_sel_data = 1'b1;
                mem_we       = w_is_store;
                if (mem_ready) begin
                    if (w_is_store) begin
                        pc_we        = 1'b1;
                        instr_done   = 1'b1;
                        w_state_next = S_FETCH;
                    end else begin
                        w_state_next = S_WB;
                    end
                end
            end
            S_WB: begin
                reg_we       = 1'b1;
                pc_we        = 1'b1;
                instr_done   = 1'b1;
                w_state_next = S_FETCH;
                if (w_is_load) begin
                    wb_sel = 2'b01;
                end else if (w_is_jal || w_is_jalr) begin
                    wb_sel = 2'b10;
                end
                if (w_is_jal) begin
                    pc_src = 2'b01;
                end else if (w_is_jalr) begin
                    pc_src = 2'b10;
                end
            end
`ifdef MULTICYCLE_CTRL_TRAP_EN
            S_TRAP: w_state_next = S_TRAP;
`endif
            default: w_state_next = S_FETCH;
        endcase

        // Reset kills any in-flight request in the same cycle, not just at the edge.
        if (reset) begin
            mem_req    = 1'b0;
            mem_we     = 1'b0;
            ir_we      = 1'b0;
            pc_we      = 1'b0;
            reg_we     = 1'b0;
            instr_done = 1'b0;
        end
    end

    assign state   = r_state;
    assign instret = r_instret;

`ifdef MULTICYCLE_CTRL_TRAP_EN
    assign trap = (r_state == S_TRAP);
`else
    assign trap = 1'b0;
`endif

endmodule
